scan_cfg_ctrl: RTL and testbench
================================

SCAN_CFG_CTRL -- requirements
Module: scan_cfg_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 29, SHALL be the total scan-chain bits: is_comb 1 + connection selects 12 + LUT 16 for the default CLB.
REQ-002 Parameter WORD_W, default 8, SHALL be the host configuration word width.
REQ-003 Port clk, input, 1: the single system clock; all state changes on posedge clk.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: starts a load/readback pass when high in IDLE.
REQ-006 Ports cfg_data (input, WORD_W) and cfg_valid (input, 1): host configuration word stream.
REQ-007 Port cfg_ready, output, 1: the word on cfg_data is accepted when cfg_valid and cfg_ready are both high.
REQ-008 Ports scan_clk, scan_en and scan_in: outputs, 1 bit each; all drive the CLB chain.
REQ-009 Port scan_out, input, 1: tail of the CLB chain.
REQ-010 Ports rd_data (output, WORD_W) and rd_valid (output, 1): returned old chain contents; rd_valid pulses for 1 cycle per word.
REQ-011 Ports busy (output, 1, high outside IDLE) and done (output, 1, 1-cycle pulse at pass end).

Function
REQ-012 The FSM SHALL have four states: IDLE, FETCH, SHIFT, FINISH.
REQ-013 Transitions SHALL be:
- IDLE->FETCH on start.
- FETCH->SHIFT on the cfg handshake.
- SHIFT->FETCH after a word's last bit while bits remain.
- SHIFT->FINISH after bit CHAIN_LEN.
- FINISH->IDLE after one cycle.
REQ-014 cfg_ready SHALL be high only in FETCH; the accepted word loads a WORD_W shift buffer.
REQ-015 Each bit SHALL take 2 clk cycles in SHIFT:
- Phase 0: scan_clk=0, scan_in=buffer LSB.
- Phase 1: scan_clk=1, giving a rising edge that shifts the chain.
REQ-016 Bits SHALL be sent word LSB first, in word order, so the first bit sent is the first bit the host supplied.
REQ-017 scan_en SHALL be high from entry to SHIFT of the first word until the cycle FINISH is entered.
- scan_en SHALL stay high through FETCH gaps.
- scan_clk SHALL be held 0 in FETCH, FINISH and IDLE.
REQ-018 A global bit counter, ceil(log2(CHAIN_LEN+1)) wide, SHALL count shifted bits from 0.
- The final word SHALL shift only CHAIN_LEN mod WORD_W bits, or WORD_W bits if that remainder is 0.
- The unused upper bits of the final word SHALL be discarded.
REQ-019 scan_out SHALL be sampled on the clk edge that ends phase 0, before the chain shifts.
- Each sample SHALL enter rd_data at the MSB and shift right.
REQ-020 rd_valid SHALL pulse 1 cycle after each WORD_W samples.
- After the final partial word, rd_valid SHALL pulse with the data right-aligned (LSB = first sample of that word) and the upper bits 0.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 A cfg_valid stall in FETCH SHALL hold scan_clk=0 and scan_en=1 indefinitely, with no timeout.
REQ-023 done SHALL assert for exactly the one cycle in FINISH.
REQ-024 cfg_data SHALL be ignored when cfg_ready is low.

Reset
REQ-025 rst SHALL asynchronously force the following, including mid-pass; no partial-pass state survives:
- The FSM to IDLE.
- Counters, buffer and rd_data to 0.
- Outputs cfg_ready, scan_clk, scan_en, scan_in, rd_valid, busy and done to 0.
REQ-026 After rst is released, the block SHALL stay idle until a new start.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding (2-bit) and the default CHAIN_LEN/WORD_W constants.
REQ-028 One sub-module, scan_bit_counter, SHALL own the bit/phase counting.
- Inputs: clear, enable.
- Outputs: phase, word-end flag, chain-end flag.

Verification
REQ-029 Load test: CHAIN_LEN=29, WORD_W=8, host words 0xA5,0x3C,0xFF,0x1B.
- Required: 29 scan_clk rising edges.
- Required: scan_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, then 1×8, then 1,1,0,1,1.
- Required: done one cycle after the last edge.
REQ-030 Readback test: a chain model preloaded with known old contents.
- Required: rd_data words 1-3 equal old bits 0-23.
- Required: the 4th rd_data equals old bits 24-28 right-aligned, upper 3 bits 0.
REQ-031 Stall test: hold cfg_valid low for 10 cycles before word 2.
- Required: scan_clk stays 0 and scan_en stays 1 throughout the stall.
- Required: the bit stream is identical to REQ-029.
REQ-032 Reset test: assert rst after bit 12.
- Required: all outputs are 0 within the same cycle and the FSM is in IDLE.
- Required: a fresh start then gives the full REQ-029 stream.
REQ-033 Start-while-busy test: pulse start during SHIFT.
- Required: no effect on the stream and only one done pulse.
REQ-034 Exact-multiple test: CHAIN_LEN=16.
- Required: exactly 2 words are fetched and rd_valid pulses twice.

Source files
------------

// File: rtl/scan_cfg_ctrl_pkg.sv
// Shared definitions for the CLB scan-chain configuration controller:
// FSM encoding and the default chain/word geometry.
package scan_cfg_ctrl_pkg;

    // is_comb (1) + connection selects (12) + LUT (16)
    localparam int DEF_CHAIN_LEN = 29;
    localparam int DEF_WORD_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/scan_cfg_ctrl_bit_counter.sv
// Bit/phase bookkeeping for the scan pass: two clk cycles per bit, a per-word
// bit index and a global bit index. Flags describe the bit currently in flight.
module scan_bit_counter
    import scan_cfg_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic phase,
    output logic word_end,
    output logic chain_end
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [BW-1:0] bit_cnt;
    logic [WW-1:0] word_cnt;

    assign word_end  = (word_cnt == WW'(WORD_W - 1));
    assign chain_end = (bit_cnt == BW'(CHAIN_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (clear) begin
            phase    <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (enable) begin
            phase <= ~phase;
            // A bit is complete once its scan_clk high phase ends
            if (phase) begin
                bit_cnt  <= bit_cnt + BW'(1);
                word_cnt <= word_end ? '0 : word_cnt + WW'(1);
            end
        end
    end

endmodule

// File: rtl/scan_cfg_ctrl.sv
// Streams host configuration words into a CLB scan chain LSB first while
// capturing the old chain contents from scan_out and returning them as words.
module scan_cfg_ctrl
    import scan_cfg_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_clk,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int REM       = CHAIN_LEN % WORD_W;
    localparam int LAST_BITS = (REM == 0) ? WORD_W : REM;
    localparam int PAD       = WORD_W - LAST_BITS;

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] shift_buf;
    logic [WORD_W-2:0] rd_shift;
    logic [WORD_W-1:0] sample_word;
    logic              en_q;
    logic              phase;
    logic              word_end;
    logic              chain_end;
    logic              accept;
    logic              sample;
    logic              bit_done;

    assign accept      = (state == FETCH) && cfg_valid;
    assign sample      = (state == SHIFT) && !phase;
    assign bit_done    = (state == SHIFT) && phase;
    assign sample_word = {scan_out, rd_shift};

    scan_bit_counter #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .enable    (state == SHIFT),
        .phase     (phase),
        .word_end  (word_end),
        .chain_end (chain_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        scan_clk   = 1'b0;
        scan_in    = 1'b0;
        scan_en    = en_q;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE:   if (start) next_state = FETCH;
            FETCH: begin
                cfg_ready = 1'b1;
                if (cfg_valid) next_state = SHIFT;
            end
            SHIFT: begin
                scan_clk = phase;
                scan_in  = shift_buf[0];
                if (phase) begin
                    if (chain_end)     next_state = FINISH;
                    else if (word_end) next_state = FETCH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_buf <= '0;
            rd_shift  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (accept)        shift_buf <= cfg_data;
            else if (bit_done) shift_buf <= shift_buf >> 1;
            // scan_out is captured at the end of phase 0, before scan_clk rises
            if (sample) begin
                rd_shift <= sample_word[WORD_W-1:1];
                if (chain_end) begin
                    rd_data  <= sample_word >> PAD;
                    rd_valid <= 1'b1;
                end else if (word_end) begin
                    rd_data  <= sample_word;
                    rd_valid <= 1'b1;
                end
            end
            if (accept)                     en_q <= 1'b1;
            else if (bit_done && chain_end) en_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Directed bench for scan_cfg_ctrl: a 29-bit and a 16-bit chain instance, each
// with a behavioural scan chain and pass monitors.
module tb_scan_cfg_ctrl;
    import scan_cfg_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start29 = 1'b0;
    logic       start16 = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;

    logic       cfg_ready29, scan_clk29, scan_en29, scan_in29, scan_out29;
    logic [7:0] rd_data29;
    logic       rd_valid29, busy29, done29;
    logic       cfg_ready16, scan_clk16, scan_en16, scan_in16, scan_out16;
    logic [7:0] rd_data16;
    logic       rd_valid16, busy16, done16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_cfg_ctrl #(.CHAIN_LEN(29), .WORD_W(8)) dut29 (
        .clk(clk), .rst(rst), .start(start29), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready29), .scan_clk(scan_clk29),
        .scan_en(scan_en29), .scan_in(scan_in29), .scan_out(scan_out29),
        .rd_data(rd_data29), .rd_valid(rd_valid29), .busy(busy29), .done(done29)
    );

    scan_cfg_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready16), .scan_clk(scan_clk16),
        .scan_en(scan_en16), .scan_in(scan_in16), .scan_out(scan_out16),
        .rd_data(rd_data16), .rd_valid(rd_valid16), .busy(busy16), .done(done16)
    );

    // Chain models: scan_in enters at the top, scan_out is bit 0
    logic        mload = 1'b0;
    logic [28:0] pre29 = '0, chain29, sin29;
    logic [15:0] pre16 = '0, chain16, sin16;
    int          edges29, edges16;

    assign scan_out29 = chain29[0];
    assign scan_out16 = chain16[0];

    always @(posedge scan_clk29 or posedge mload) begin
        if (mload) begin
            chain29 <= pre29; edges29 <= 0; sin29 <= '0;
        end else begin
            chain29 <= {scan_in29, chain29[28:1]};
            if (edges29 < 29) sin29[5'(edges29)] <= scan_in29;
            edges29 <= edges29 + 1;
        end
    end

    always @(posedge scan_clk16 or posedge mload) begin
        if (mload) begin
            chain16 <= pre16; edges16 <= 0; sin16 <= '0;
        end else begin
            chain16 <= {scan_in16, chain16[15:1]};
            if (edges16 < 16) sin16[4'(edges16)] <= scan_in16;
            edges16 <= edges16 + 1;
        end
    end

    int         done_cnt29, rd_cnt29, fetch29, done_cnt16, rd_cnt16, fetch16;
    logic [7:0] rd29 [4];
    logic [7:0] rd16 [2];
    logic       sclk_d29, done_after_edge29, en_at_done29;

    always @(posedge clk) begin
        if (mload) begin
            done_cnt29 <= 0; rd_cnt29 <= 0; fetch29 <= 0;
            done_cnt16 <= 0; rd_cnt16 <= 0; fetch16 <= 0;
            sclk_d29 <= 1'b0; done_after_edge29 <= 1'b0; en_at_done29 <= 1'b1;
            for (int i = 0; i < 4; i++) rd29[i] <= 8'hxx;
            for (int i = 0; i < 2; i++) rd16[i] <= 8'hxx;
        end else begin
            sclk_d29 <= scan_clk29;
            if (done29) begin
                done_cnt29        <= done_cnt29 + 1;
                done_after_edge29 <= sclk_d29;
                en_at_done29      <= scan_en29;
            end
            if (rd_valid29) begin
                if (rd_cnt29 < 4) rd29[2'(rd_cnt29)] <= rd_data29;
                rd_cnt29 <= rd_cnt29 + 1;
            end
            if (cfg_valid && cfg_ready29) fetch29 <= fetch29 + 1;
            if (done16) done_cnt16 <= done_cnt16 + 1;
            if (rd_valid16) begin
                if (rd_cnt16 < 2) rd16[1'(rd_cnt16)] <= rd_data16;
                rd_cnt16 <= rd_cnt16 + 1;
            end
            if (cfg_valid && cfg_ready16) fetch16 <= fetch16 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [28:0] p29, input logic [15:0] p16);
        pre29 = p29;
        pre16 = p16;
        @(negedge clk) mload = 1'b1;
        @(negedge clk) mload = 1'b0;
    endtask

    task automatic wait_ready(input bit s16);
        int n = 0;
        while (!(s16 ? cfg_ready16 : cfg_ready29) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait", 32'(n < 1000), 32'd1);
    endtask

    task automatic send_word(input bit s16, input logic [7:0] w);
        cfg_data  = w;
        cfg_valid = 1'b1;
        wait_ready(s16);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic stall_check(input bit s16);
        cfg_valid = 1'b0;
        wait_ready(s16);
        repeat (10) begin
            @(negedge clk);
            chk("stall_scan_clk", 32'(s16 ? scan_clk16 : scan_clk29), 32'd0);
            chk("stall_scan_en", 32'(s16 ? scan_en16 : scan_en29), 32'd1);
        end
    endtask

    task automatic run_pass(input bit s16, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input int nwords, input int stall_idx, input bit poke);
        logic [7:0] w [4];
        int n;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(negedge clk);
        if (s16) start16 = 1'b1; else start29 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        start29 = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            if (k == stall_idx) stall_check(s16);
            send_word(s16, w[k]);
            if (poke && k == 0) begin
                @(negedge clk) start29 = 1'b1;
                @(negedge clk) start29 = 1'b0;
            end
        end
        n = 0;
        while ((s16 ? busy16 : busy29) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("pass_end_wait", 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_pass29(input string p, input logic [7:0] r0, input logic [7:0] r1,
                                input logic [7:0] r2, input logic [7:0] r3);
        chk({p, "_edges"}, 32'(edges29), 32'd29);
        chk({p, "_scan_in_stream"}, 32'(sin29), 32'h1BFF3CA5);
        chk({p, "_chain_final"}, 32'(chain29), 32'h1BFF3CA5);
        chk({p, "_done_count"}, 32'(done_cnt29), 32'd1);
        chk({p, "_done_after_last_edge"}, 32'(done_after_edge29), 32'd1);
        chk({p, "_scan_en_in_finish"}, 32'(en_at_done29), 32'd0);
        chk({p, "_fetch_count"}, 32'(fetch29), 32'd4);
        chk({p, "_rd_count"}, 32'(rd_cnt29), 32'd4);
        chk({p, "_rd0"}, 32'(rd29[0]), 32'(r0));
        chk({p, "_rd1"}, 32'(rd29[1]), 32'(r1));
        chk({p, "_rd2"}, 32'(rd29[2]), 32'(r2));
        chk({p, "_rd3"}, 32'(rd29[3]), 32'(r3));
    endtask

    initial begin
        int n;

        // Reset state
        model_load(29'h0, 16'h0);
        @(negedge clk);
        chk("rst_ctrl_outputs", 32'({cfg_ready29, scan_clk29, scan_en29, scan_in29,
                                     rd_valid29, busy29, done29}), 32'd0);
        chk("rst_rd_data", 32'(rd_data29), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst", 32'(busy29), 32'd0);

        // Load and readback: old bits 0-23 = B7,E1,AC; bits 24-28 = 10101
        model_load(29'h15ACE1B7, 16'h0);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'hFF, 8'h1B, 4, -1, 1'b0);
        check_pass29("load", 8'hB7, 8'hE1, 8'hAC, 8'h15);

        // Ten-cycle cfg_valid stall before word 2
        model_load(29'h01234567, 16'h0);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'hFF, 8'h1B, 4, 1, 1'b0);
        check_pass29("stall", 8'h67, 8'h45, 8'h23, 8'h01);

        // start pulsed while shifting
        model_load(29'h0, 16'h0);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'hFF, 8'h1B, 4, -1, 1'b1);
        check_pass29("busy_start", 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (10) @(negedge clk);
        chk("busy_start_no_rerun", 32'(busy29), 32'd0);
        chk("busy_start_done_total", 32'(done_cnt29), 32'd1);

        // Asynchronous reset in the middle of word 2
        model_load(29'h0, 16'h0);
        @(negedge clk) start29 = 1'b1;
        @(negedge clk) start29 = 1'b0;
        send_word(1'b0, 8'hA5);
        send_word(1'b0, 8'h3C);
        n = 0;
        while (edges29 < 12 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_wait", 32'(n < 1000), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctrl_outputs", 32'({cfg_ready29, scan_clk29, scan_en29, scan_in29,
                                         rd_valid29, busy29, done29}), 32'd0);
        chk("rst_mid_rd_data", 32'(rd_data29), 32'd0);
        chk("rst_mid_state", 32'(dut29.state), 32'(IDLE));
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_stays_idle", 32'(busy29), 32'd0);
        model_load(29'h1E0F55AA, 16'h0);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'hFF, 8'h1B, 4, -1, 1'b0);
        check_pass29("after_rst", 8'hAA, 8'h55, 8'h0F, 8'h1E);

        // Chain length an exact multiple of the word width
        model_load(29'h0, 16'hBEEF);
        run_pass(1'b1, 8'h5A, 8'hC3, 8'h00, 8'h00, 2, -1, 1'b0);
        chk("x16_edges", 32'(edges16), 32'd16);
        chk("x16_scan_in_stream", 32'(sin16), 32'h0000C35A);
        chk("x16_chain_final", 32'(chain16), 32'h0000C35A);
        chk("x16_fetch_count", 32'(fetch16), 32'd2);
        chk("x16_rd_count", 32'(rd_cnt16), 32'd2);
        chk("x16_rd0", 32'(rd16[0]), 32'h000000EF);
        chk("x16_rd1", 32'(rd16[1]), 32'h000000BE);
        chk("x16_done_count", 32'(done_cnt16), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
